axi4l_scratch_regs: RTL and testbench



---
 rtl/axi4l_if.sv | 47 ++++
 rtl/axi4l_scratch_regs.sv | 186 ++++++++++++++++++
 tb/tb_axi4l_scratch_regs.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4l_if.sv
// AXI4-Lite channel bundle shared by masters and responders on the fabric.
// aresetn is carried for masters; responders on this fabric use their own rst.
interface axi4l_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                      aresetn;

    logic [ADDR_WIDTH-1:0]     awaddr;
    logic                      awvalid;
    logic                      awready;

    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic                      wvalid;
    logic                      wready;

    logic [1:0]                bresp;
    logic                      bvalid;
    logic                      bready;

    logic [ADDR_WIDTH-1:0]     araddr;
    logic                      arvalid;
    logic                      arready;

    logic [DATA_WIDTH-1:0]     rdata;
    logic [1:0]                rresp;
    logic                      rvalid;
    logic                      rready;

    modport MASTER (
        output aresetn,
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport SLAVE (
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axi4l_scratch_regs.sv
// AXI4-Lite responder with a bank of byte-writable scratch registers behind a
// base-address decode; one outstanding write and one outstanding read.
module axi4l_scratch_regs #(
    parameter int unsigned ADDR_WIDTH       = 32,
    parameter int unsigned DATA_WIDTH       = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_OFFSET      = 32'h8000_0000,
    parameter logic [ADDR_WIDTH-1:0] BASE_OFFSET_MASK = 32'hFFFF_F000,
    parameter int unsigned NUM_REGS         = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE      = 32'h0000_0000
) (
    input  logic      clk,
    input  logic      rst,
    axi4l_if.SLAVE    intf
);
    localparam int unsigned IDX_W  = $clog2(NUM_REGS);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wr_state_e;
    typedef enum logic       {R_IDLE, R_RESP} rd_state_e;

    wr_state_e             wr_state_q, wr_state_d;
    rd_state_e             rd_state_q, rd_state_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic                  aw_full_q, aw_full_d;
    logic                  w_full_q, w_full_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    function automatic logic addr_hit(input logic [ADDR_WIDTH-1:0] a);
        return (a & BASE_OFFSET_MASK) == BASE_OFFSET;
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
        return a[2 +: IDX_W];
    endfunction

    always_comb begin
        wr_state_d = wr_state_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        aw_full_d  = aw_full_q;
        w_full_d   = w_full_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        regs_d     = regs_q;

        if (intf.awvalid && awready_q) begin
            awaddr_d  = intf.awaddr;
            aw_full_d = 1'b1;
        end
        if (intf.wvalid && wready_q) begin
            wdata_d  = intf.wdata;
            wstrb_d  = intf.wstrb;
            w_full_d = 1'b1;
        end

        // The commit uses the just-captured halves so BVALID follows the later
        // handshake by one cycle rather than two.
        if (wr_state_q == W_RESP) begin
            if (intf.bready) begin
                wr_state_d = W_IDLE;
                aw_full_d  = 1'b0;
                w_full_d   = 1'b0;
                bvalid_d   = 1'b0;
            end
        end else if (aw_full_d && w_full_d) begin
            wr_state_d = W_RESP;
            bvalid_d   = 1'b1;
            if (addr_hit(awaddr_d)) begin
                bresp_d = RESP_OKAY;
                for (int unsigned n = 0; n < STRB_W; n++) begin
                    if (wstrb_d[n]) begin
                        regs_d[addr_idx(awaddr_d)][8*n +: 8] = wdata_d[8*n +: 8];
                    end
                end
            end else begin
                bresp_d = RESP_DECERR;
            end
        end else if (aw_full_d) begin
            wr_state_d = W_HAVE_AW;
        end else if (w_full_d) begin
            wr_state_d = W_HAVE_W;
        end else begin
            wr_state_d = W_IDLE;
        end

        awready_d = !aw_full_d && (wr_state_d != W_RESP);
        wready_d  = !w_full_d && (wr_state_d != W_RESP);
    end

    always_comb begin
        rd_state_d = rd_state_q;
        arready_d  = arready_q;
        rvalid_d   = rvalid_q;
        rresp_d    = rresp_q;
        rdata_d    = rdata_q;

        case (rd_state_q)
            R_IDLE: begin
                if (intf.arvalid && arready_q) begin
                    rd_state_d = R_RESP;
                    arready_d  = 1'b0;
                    rvalid_d   = 1'b1;
                    // Reads sample the pre-commit bank, so a same-cycle write loses.
                    if (addr_hit(intf.araddr)) begin
                        rdata_d = regs_q[addr_idx(intf.araddr)];
                        rresp_d = RESP_OKAY;
                    end else begin
                        rdata_d = '0;
                        rresp_d = RESP_DECERR;
                    end
                end
            end
            R_RESP: begin
                if (intf.rready) begin
                    rd_state_d = R_IDLE;
                    arready_d  = 1'b1;
                    rvalid_d   = 1'b0;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state_q <= W_IDLE;
            rd_state_q <= R_IDLE;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            aw_full_q  <= 1'b0;
            w_full_q   <= 1'b0;
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
            bvalid_q   <= 1'b0;
            bresp_q    <= '0;
            arready_q  <= 1'b1;
            rvalid_q   <= 1'b0;
            rresp_q    <= '0;
            rdata_q    <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VALUE;
            end
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            aw_full_q  <= aw_full_d;
            w_full_q   <= w_full_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
            regs_q     <= regs_d;
        end
    end

    assign intf.awready = awready_q;
    assign intf.wready  = wready_q;
    assign intf.bvalid  = bvalid_q;
    assign intf.bresp   = bresp_q;
    assign intf.arready = arready_q;
    assign intf.rvalid  = rvalid_q;
    assign intf.rresp   = rresp_q;
    assign intf.rdata   = rdata_q;
endmodule

// File: tb/tb_axi4l_scratch_regs.sv
// Bench for axi4l_scratch_regs: directed vector table, multi-cycle corner
// sequences and randomized traffic against a word-array reference model.
module tb_axi4l_scratch_regs;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi4l_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) intf ();

    axi4l_scratch_regs #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32),
        .BASE_OFFSET(32'h8000_0000), .BASE_OFFSET_MASK(32'hFFFF_F000),
        .NUM_REGS(16), .RESET_VALUE(32'h0000_0000)
    ) dut (.clk(clk), .rst(rst), .intf(intf));

    localparam logic [1:0] OKAY = 2'b00, DECERR = 2'b11;

    int checks = 0;
    int errors = 0;
    logic [31:0] mem [16];

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
    } vec_t;
    vec_t tv[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic bit m_hit(input logic [31:0] a);
        return a[31:12] == 20'h80000;
    endfunction

    function automatic void m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (m_hit(a))
            for (int b = 0; b < 4; b++)
                if (s[b]) mem[a[5:2]][8*b +: 8] = d[8*b +: 8];
    endfunction

    // Tasks start and finish just after a falling edge.
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int bstall,
                             output logic [1:0] resp);
        bit aw_done = 0, w_done = 0, aw_f, w_f, proto_err = 0, ok = 1;
        int cyc = 0;
        intf.awaddr = a; intf.wdata = d; intf.wstrb = s;
        intf.bready = (bstall == 0);
        while (!(aw_done && w_done) && cyc < 50) begin
            intf.awvalid = !aw_done && (cyc >= aw_dly);
            intf.wvalid  = !w_done && (cyc >= w_dly);
            if (intf.bvalid || (aw_done && intf.awready) || (w_done && intf.wready)) proto_err = 1;
            aw_f = intf.awvalid && intf.awready;
            w_f  = intf.wvalid && intf.wready;
            @(negedge clk);
            cyc++;
            if (aw_f) aw_done = 1;
            if (w_f) w_done = 1;
        end
        intf.awvalid = 0; intf.wvalid = 0;
        check("aw_w_handshake", {31'b0, aw_done && w_done}, 1);
        check("wr_hold_ready_low", {31'b0, proto_err}, 0);
        check("bvalid_latency", {31'b0, intf.bvalid}, 1);
        resp = intf.bresp;
        if (bstall > 0) begin
            repeat (bstall) begin
                @(negedge clk);
                if (!intf.bvalid || intf.awready || intf.wready || intf.bresp !== resp) ok = 0;
            end
            check("b_stall_hold", {31'b0, ok}, 1);
            intf.bready = 1;
        end
        @(negedge clk);
    endtask

    task automatic axi_read(input logic [31:0] a, input int rstall,
                            output logic [31:0] d, output logic [1:0] r);
        bit fired = 0, ok = 1;
        int cyc = 0;
        intf.araddr = a; intf.arvalid = 1;
        intf.rready = (rstall == 0);
        while (!fired && cyc < 50) begin
            fired = intf.arready;
            @(negedge clk);
            cyc++;
        end
        intf.arvalid = 0;
        check("ar_handshake", {31'b0, fired}, 1);
        check("rvalid_latency", {31'b0, intf.rvalid}, 1);
        d = intf.rdata; r = intf.rresp;
        if (rstall > 0) begin
            repeat (rstall) begin
                @(negedge clk);
                if (!intf.rvalid || intf.arready || intf.rdata !== d || intf.rresp !== r) ok = 0;
            end
            check("r_stall_hold", {31'b0, ok}, 1);
            intf.rready = 1;
        end
        @(negedge clk);
    endtask

    function automatic void add_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                                  input logic [1:0] r);
        tv.push_back('{1'b1, a, d, s, 32'h0, r});
    endfunction

    function automatic void add_r(input logic [31:0] a, input logic [31:0] e, input logic [1:0] r);
        tv.push_back('{1'b0, a, 32'h0, 4'h0, e, r});
    endfunction

    initial begin
        logic [1:0]  resp;
        logic [31:0] rd;
        logic [31:0] a;
        logic [31:0] v;

        intf.aresetn = 1;
        intf.awaddr = '0; intf.awvalid = 0; intf.wdata = '0; intf.wstrb = '0; intf.wvalid = 0;
        intf.bready = 1; intf.araddr = '0; intf.arvalid = 0; intf.rready = 1;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        rst = 1;
        repeat (3) @(negedge clk);
        rst = 0;

        check("rst_awready", {31'b0, intf.awready}, 1);
        check("rst_wready",  {31'b0, intf.wready}, 1);
        check("rst_arready", {31'b0, intf.arready}, 1);
        check("rst_bvalid",  {31'b0, intf.bvalid}, 0);
        check("rst_rvalid",  {31'b0, intf.rvalid}, 0);
        check("rst_bresp",   {30'b0, intf.bresp}, 0);
        check("rst_rresp",   {30'b0, intf.rresp}, 0);
        check("rst_rdata",   intf.rdata, 0);

        add_r(32'h8000_003C, 32'h0, OKAY);
        for (int i = 0; i < 4; i++) begin
            add_w(32'h8000_003C, 32'h0, 4'hF, OKAY);
            add_w(32'h8000_003C, 32'hFFFF_FFFF, 4'(1 << i), OKAY);
            add_r(32'h8000_003C, 32'hFF << (8 * i), OKAY);
        end
        add_w(32'h8000_003C, 32'h0, 4'hF, OKAY);
        add_r(32'h8000_003C, 32'h0, OKAY);
        add_r(32'h8000_0038, 32'h0, OKAY);
        add_w(32'h8000_003C, 32'h1234_1234, 4'h3, OKAY);
        add_r(32'h8000_003C, 32'h0000_1234, OKAY);
        add_w(32'h8000_003C, 32'h0, 4'hF, OKAY);
        add_w(32'h8000_003C, 32'h1234_1234, 4'hC, OKAY);
        add_r(32'h8000_003C, 32'h1234_0000, OKAY);
        add_w(32'h8000_003C, 32'hABAB_ABAB, 4'h8, OKAY);
        add_r(32'h8000_003C, 32'hAB34_0000, OKAY);
        add_w(32'h9000_003C, 32'hDEAD_BEEF, 4'hF, DECERR);
        add_r(32'h9000_003C, 32'h0, DECERR);
        add_r(32'h8000_003C, 32'hAB34_0000, OKAY);
        add_w(32'h8000_003C, 32'hFFFF_FFFF, 4'h0, OKAY);
        add_r(32'h8000_0FFF, 32'hAB34_0000, OKAY);

        foreach (tv[i]) begin
            if (tv[i].wr) begin
                axi_write(tv[i].addr, tv[i].data, tv[i].strb, 0, 0, 0, resp);
                check($sformatf("tv%0d_bresp", i), {30'b0, resp}, {30'b0, tv[i].exp_r});
                m_write(tv[i].addr, tv[i].data, tv[i].strb);
            end else begin
                axi_read(tv[i].addr, 0, rd, resp);
                check($sformatf("tv%0d_rdata", i), rd, tv[i].exp_d);
                check($sformatf("tv%0d_rresp", i), {30'b0, resp}, {30'b0, tv[i].exp_r});
            end
        end

        // W five cycles ahead of AW, then a 10-cycle BREADY stall.
        axi_write(32'h8000_0000, 32'hCAFE_F00D, 4'hF, 5, 0, 10, resp);
        check("wfirst_bresp", {30'b0, resp}, {30'b0, OKAY});
        m_write(32'h8000_0000, 32'hCAFE_F00D, 4'hF);
        axi_read(32'h8000_0000, 10, rd, resp);
        check("rstall_rdata", rd, 32'hCAFE_F00D);

        // Same-cycle AR and write commit on index 15.
        axi_write(32'h8000_003C, 32'h1111_1111, 4'hF, 0, 0, 0, resp);
        m_write(32'h8000_003C, 32'h1111_1111, 4'hF);
        intf.awaddr = 32'h8000_003C; intf.wdata = 32'h2222_2222; intf.wstrb = 4'hF;
        intf.araddr = 32'h8000_003C;
        intf.awvalid = 1; intf.wvalid = 1; intf.arvalid = 1;
        intf.bready = 1; intf.rready = 1;
        @(negedge clk);
        intf.awvalid = 0; intf.wvalid = 0; intf.arvalid = 0;
        check("col_bvalid", {31'b0, intf.bvalid}, 1);
        check("col_rvalid", {31'b0, intf.rvalid}, 1);
        check("col_rdata_old", intf.rdata, 32'h1111_1111);
        @(negedge clk);
        m_write(32'h8000_003C, 32'h2222_2222, 4'hF);
        axi_read(32'h8000_003C, 0, rd, resp);
        check("col_rdata_new", rd, 32'h2222_2222);

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 3) == 0) a = $urandom;
            else a = {20'h80000, 12'($urandom)};
            if ($urandom_range(0, 1) == 1) begin
                v = $urandom;
                rd = {28'b0, 4'($urandom_range(0, 15))};
                axi_write(a, v, rd[3:0], $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 2), resp);
                check($sformatf("rnd%0d_bresp", n), {30'b0, resp}, m_hit(a) ? 32'h0 : 32'h3);
                m_write(a, v, rd[3:0]);
            end else begin
                axi_read(a, $urandom_range(0, 2), rd, resp);
                check($sformatf("rnd%0d_rdata", n), rd, m_hit(a) ? mem[a[5:2]] : 32'h0);
                check($sformatf("rnd%0d_rresp", n), {30'b0, resp}, m_hit(a) ? 32'h0 : 32'h3);
            end
        end

        // Reset asserted mid-cycle while BVALID is held.
        intf.bready = 0;
        intf.awaddr = 32'h8000_0010; intf.wdata = 32'h5A5A_5A5A; intf.wstrb = 4'hF;
        intf.awvalid = 1; intf.wvalid = 1;
        @(negedge clk);
        intf.awvalid = 0; intf.wvalid = 0;
        check("pre_rst_bvalid", {31'b0, intf.bvalid}, 1);
        #2 rst = 1;
        #1 check("rst_async_bvalid", {31'b0, intf.bvalid}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        intf.bready = 1;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        check("post_rst_awready", {31'b0, intf.awready}, 1);
        check("post_rst_wready", {31'b0, intf.wready}, 1);
        axi_read(32'h8000_0010, 0, rd, resp);
        check("post_rst_reg4", rd, mem[4]);
        axi_read(32'h8000_003C, 0, rd, resp);
        check("post_rst_reg15", rd, mem[15]);
        axi_write(32'h8000_0008, 32'h0BAD_F00D, 4'hF, 0, 0, 0, resp);
        check("post_rst_bresp", {30'b0, resp}, 0);
        axi_read(32'h8000_0008, 0, rd, resp);
        check("post_rst_rdata", rd, 32'h0BAD_F00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
